// File: rtl/ram_pkg.sv
// Shared types and constants for the multi-port register-file RAM family.
package ram_pkg;

    localparam int unsigned RAM_MAX_PORTS = 8;
    localparam int unsigned RAM_LAT_COMB  = 0;
    localparam int unsigned RAM_LAT_REG   = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/ram_clear_sweep.sv
// Sweep-clear sequencer: walks the array one entry per cycle after reset or flush,
// holding busy_o high until the last entry has been cleared.
module ram_clear_sweep
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned INDEX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    output logic             clr_en_o,
    output logic [INDEX-1:0] clr_addr_o,
    output logic             busy_o
);

    localparam logic [INDEX-1:0] LastPtr = INDEX'(DEPTH - 1);

    sweep_state_e     state_q, state_d;
    logic [INDEX-1:0] ptr_q, ptr_d;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d == CLEAR);
        end
    end

    // A flush restarts the walk from entry 0 even when a sweep is already running.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (flush_i) begin
            state_d = CLEAR;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    if (ptr_q == LastPtr) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + INDEX'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        clr_en_o   = (state_q == CLEAR);
        clr_addr_o = ptr_q;
        busy_o     = busy_q;
    end

endmodule

// File: rtl/ram_mrmw_sweep.sv
// Multi-read/multi-write register-file RAM with optional registered read and bypass.
// Define RAM_SWEEP_CLEAR_EN to replace the single-edge bulk clear with a sweep-clear FSM.
module ram_mrmw_sweep
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned INDEX  = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned RD_LAT = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic [NUM_RD-1:0][INDEX-1:0]   addr_rd_i,
    output logic [NUM_RD-1:0][WIDTH-1:0]   data_rd_o,
    input  logic [NUM_WR-1:0][INDEX-1:0]   addr_wr_i,
    input  logic [NUM_WR-1:0][WIDTH-1:0]   data_wr_i,
    input  logic [NUM_WR-1:0]              we_i,
    output logic                           wr_conflict_o,
    output logic                           busy_o
);

    localparam logic [INDEX:0] DepthExt = (INDEX + 1)'(DEPTH);

    if (DEPTH == 0 || ((DEPTH - 1) >> INDEX) != 0) begin : g_chk_index
        $error("ram_mrmw_sweep: INDEX too narrow for DEPTH");
    end
    if (RD_LAT != RAM_LAT_COMB && RD_LAT != RAM_LAT_REG) begin : g_chk_lat
        $error("ram_mrmw_sweep: RD_LAT must be 0 or 1");
    end
    if (NUM_RD < 1 || NUM_RD > RAM_MAX_PORTS) begin : g_chk_rd
        $error("ram_mrmw_sweep: NUM_RD out of range");
    end
    if (NUM_WR < 1 || NUM_WR > RAM_MAX_PORTS) begin : g_chk_wr
        $error("ram_mrmw_sweep: NUM_WR out of range");
    end

    logic                         busy;
    logic [NUM_WR-1:0]            wr_ok;
    logic [NUM_RD-1:0][WIDTH-1:0] arr_rd;
    logic                         conflict;
    logic                         wr_conflict_q;
    logic [WIDTH-1:0]             mem_q [DEPTH];

`ifdef RAM_SWEEP_CLEAR_EN
    logic             clr_en;
    logic [INDEX-1:0] clr_addr;

    ram_clear_sweep #(
        .DEPTH (DEPTH),
        .INDEX (INDEX)
    ) u_clear_sweep (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush_i),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );
`else
    assign busy = 1'b0;
`endif

    // A write only lands when in range and no clear of any kind is in progress.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_ok[p] = we_i[p] && ({1'b0, addr_wr_i[p]} < DepthExt) && !reset && !flush_i
                       && !busy;
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (we_i[i] && we_i[j] && (addr_wr_i[i] == addr_wr_i[j])) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    // Ports are applied in ascending order so the highest-numbered port wins.
    always_ff @(posedge clk) begin
`ifdef RAM_SWEEP_CLEAR_EN
        if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end
`else
        if (reset || flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end
`endif
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_ok[p]) begin
                mem_q[addr_wr_i[p]] <= data_wr_i[p];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            arr_rd[r] = '0;
            if ({1'b0, addr_rd_i[r]} < DepthExt) begin
                arr_rd[r] = mem_q[addr_rd_i[r]];
            end
        end
    end

    if (RD_LAT == RAM_LAT_REG) begin : g_rd_reg
        logic [NUM_RD-1:0][WIDTH-1:0] rd_next;
        logic [NUM_RD-1:0][WIDTH-1:0] data_rd_q;

        always_comb begin
            for (int r = 0; r < NUM_RD; r++) begin
                rd_next[r] = arr_rd[r];
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_ok[p] && (addr_wr_i[p] == addr_rd_i[r])) begin
                        rd_next[r] = data_wr_i[p];
                    end
                end
                if (busy) begin
                    rd_next[r] = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_rd_q <= '0;
            end else begin
                data_rd_q <= rd_next;
            end
        end

        assign data_rd_o = data_rd_q;
    end else begin : g_rd_comb
        assign data_rd_o = busy ? '0 : arr_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= conflict && !busy;
        end
    end

    assign wr_conflict_o = wr_conflict_q;
    assign busy_o        = busy;

endmodule

// File: tb/tb_ram_mrmw_sweep.sv
// Scoreboard bench: two RAM instances (combinational read, DEPTH 16; registered read, DEPTH 12)
// driven in lockstep and compared against an array-level reference model.
module tb_ram_mrmw_sweep;

`ifdef RAM_SWEEP_CLEAR_EN
    localparam bit Sweep = 1'b1;
`else
    localparam bit Sweep = 1'b0;
`endif
    localparam int Depth0 = 16;
    localparam int Depth1 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset   = 1'b1;
    logic            flush   = 1'b0;
    logic [1:0][3:0] addr_rd = '0;
    logic [1:0][3:0] addr_wr = '0;
    logic [1:0][7:0] data_wr = '0;
    logic [1:0]      we      = '0;
    logic [1:0][7:0] rd0, rd1;
    logic            conf0, conf1, busy0, busy1;

    ram_mrmw_sweep #(
        .DEPTH(Depth0), .INDEX(4), .WIDTH(8), .NUM_RD(2), .NUM_WR(2), .RD_LAT(0)
    ) u_dut0 (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush),
        .addr_rd_i     (addr_rd),
        .data_rd_o     (rd0),
        .addr_wr_i     (addr_wr),
        .data_wr_i     (data_wr),
        .we_i          (we),
        .wr_conflict_o (conf0),
        .busy_o        (busy0)
    );

    ram_mrmw_sweep #(
        .DEPTH(Depth1), .INDEX(4), .WIDTH(8), .NUM_RD(2), .NUM_WR(2), .RD_LAT(1)
    ) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush),
        .addr_rd_i     (addr_rd),
        .data_rd_o     (rd1),
        .addr_wr_i     (addr_wr),
        .data_wr_i     (data_wr),
        .we_i          (we),
        .wr_conflict_o (conf1),
        .busy_o        (busy1)
    );

    typedef struct packed {
        logic [1:0][1:0][7:0] rd;
        logic [1:0]           conf;
        logic [1:0]           busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: array contents, registered read data, conflict flag, busy countdown.
    int         depth_m [2] = '{Depth0, Depth1};
    logic [7:0] mem_m   [2][16];
    logic [7:0] rdq_m   [2];
    logic       conf_m  [2];
    int         cnt_m   [2];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %02h required %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int r = 0; r < 2; r++) begin
                check($sformatf("dut0_rd%0d", r), rd0[r], e.rd[0][r]);
                check($sformatf("dut1_rd%0d", r), rd1[r], e.rd[1][r]);
            end
            check("dut0_conflict", {7'b0, conf0}, {7'b0, e.conf[0]});
            check("dut1_conflict", {7'b0, conf1}, {7'b0, e.conf[1]});
            check("dut0_busy", {7'b0, busy0}, {7'b0, e.busy[0]});
            check("dut1_busy", {7'b0, busy1}, {7'b0, e.busy[1]});
        end
    end

    task automatic cyc(input logic r, input logic f, input logic [1:0] w, input int a0,
                       input int a1, input int d0, input int d1, input int q0, input int q1);
        int         wa[2];
        int         wd[2];
        int         ra[2];
        exp_t       e;
        logic       busy;
        logic       ok[2];
        logic [7:0] v;
        wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1; ra[0] = q0; ra[1] = q1;
        @(posedge clk);
        #2;
        reset = r;
        flush = f;
        we    = w;
        for (int p = 0; p < 2; p++) begin
            addr_wr[p] = 4'(wa[p]);
            data_wr[p] = 8'(wd[p]);
            addr_rd[p] = 4'(ra[p]);
        end
        for (int d = 0; d < 2; d++) begin
            busy      = (cnt_m[d] > 0);
            e.busy[d] = busy;
            e.conf[d] = conf_m[d];
            for (int k = 0; k < 2; k++) begin
                v = (busy || ra[k] >= depth_m[d]) ? 8'h00 : mem_m[d][ra[k]];
                e.rd[d][k] = (d == 0) ? v : rdq_m[k];
            end
        end
        sb.push_back(e);
        for (int d = 0; d < 2; d++) begin
            busy      = (cnt_m[d] > 0);
            conf_m[d] = !r && !busy && w[0] && w[1] && (wa[0] == wa[1]);
            for (int p = 0; p < 2; p++) begin
                ok[p] = w[p] && (wa[p] < depth_m[d]) && !r && !f && !busy;
            end
            if (d == 1) begin
                for (int k = 0; k < 2; k++) begin
                    v = (ra[k] < depth_m[d]) ? mem_m[d][ra[k]] : 8'h00;
                    for (int p = 0; p < 2; p++) begin
                        if (ok[p] && wa[p] == ra[k]) v = 8'(wd[p]);
                    end
                    if (busy || r) v = 8'h00;
                    rdq_m[k] = v;
                end
            end
            if (r || f) begin
                for (int i = 0; i < 16; i++) mem_m[d][i] = 8'h00;
                cnt_m[d] = Sweep ? depth_m[d] : 0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (ok[p]) mem_m[d][wa[p]] = 8'(wd[p]);
                end
                if (cnt_m[d] > 0) cnt_m[d]--;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, $urandom_range(0, 15), $urandom_range(0, 15));
        end
    endtask

    task automatic rand_cyc(input logic allow_ctl);
        logic r;
        logic f;
        r = allow_ctl && ($urandom_range(0, 299) == 0);
        f = allow_ctl && ($urandom_range(0, 63) == 0);
        cyc(r, f, 2'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mem_m[d][i] = 8'h00;
            rdq_m[d]  = 8'h00;
            conf_m[d] = 1'b0;
            cnt_m[d]  = Sweep ? depth_m[d] : 0;
        end

        cyc(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 0, 1);
        cyc(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 2, 3);
        idle(18);

        // Write-write priority on address 5, then a quiet cycle to see the pulse end.
        cyc(1'b0, 1'b0, 2'b11, 5, 5, 8'h11, 8'h22, 5, 5);
        cyc(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 5, 5);
        cyc(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 5, 4);

        // Same-cycle read of a written address.
        cyc(1'b0, 1'b0, 2'b01, 3, 0, 8'hAB, 0, 3, 3);
        cyc(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 3, 3);

        // Out-of-range for the DEPTH 12 instance only.
        cyc(1'b0, 1'b0, 2'b11, 13, 12, 8'h5A, 8'h6B, 13, 12);
        cyc(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 13, 12);
        cyc(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 11, 15);

        // Flush beats a simultaneous write.
        cyc(1'b0, 1'b0, 2'b01, 7, 0, 8'h77, 0, 7, 7);
        cyc(1'b0, 1'b1, 2'b01, 7, 0, 8'h99, 0, 7, 7);
        idle(18);

        // Fill with 0xFF, flush, write during any clear, restart at cycle 7, then reset mid-sweep.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 2'b01, i, 0, 8'hFF, 0, i, 15 - i);
        cyc(1'b0, 1'b1, 2'b00, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'b01, i, 0, 8'hC3, 0, i, i + 8);
        cyc(1'b0, 1'b1, 2'b00, 0, 0, 0, 0, 2, 3);
        for (int i = 0; i < 18; i++) cyc(1'b0, 1'b0, 2'b10, 0, i % 16, 0, 8'h3C, i % 16, 15);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 2'b10, 0, i, 0, 8'hFF, i, 0);
        cyc(1'b0, 1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(5);
        cyc(1'b1, 1'b0, 2'b11, 1, 2, 8'h01, 8'h02, 1, 2);
        for (int i = 0; i < 18; i++) cyc(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, i % 16, (i + 5) % 16);

        for (int i = 0; i < 1500; i++) rand_cyc(1'b1);
        idle(18);
        for (int i = 0; i < 300; i++) rand_cyc(1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
